// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared playfield constants, position type and LED decode
// Also used by the victory checker.
package tug_pkg;

    localparam int N_LEDS     = 9;
    localparam int POS_CENTRE = 5;
    localparam int POS_MIN    = 1;
    localparam int POS_MAX    = 9;

    typedef logic [3:0] pos_t;

    // One-hot decode: position p lights bit p-1; out-of-range codes light nothing.
    function automatic logic [N_LEDS-1:0] pos_to_led(input pos_t p);
        logic [N_LEDS-1:0] v;
        v = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (p == pos_t'(i + 1)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/tug_key_cond.sv
// rtl/tug_key_cond.sv - key synchronizer, optional debounce and rising-edge press pulse
// Ports: clk, reset (sync, active-high), key (raw async level), press (one-cycle pulse).
// Optional feature: TUG_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stability filter after the synchronizer.
module tug_key_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync1;
    logic sync2;
    logic level;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

`ifdef TUG_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          acc;

    // The counter runs only while sync2 disagrees with the accepted level;
    // any return to agreement clears it, so short bounces never get through.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            acc <= 1'b0;
        end else if (sync2 == acc) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            acc <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = acc;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    // Both terms are registers, so the pulse is clean for the whole cycle.
    assign press = level & ~prev;

endmodule

// File: rtl/tug_field.sv
// rtl/tug_field.sv - tug-of-war playfield: press conditioning and one-hot light position
// Ports: clk, reset (sync, active-high), key_l/key_r (raw keys), freeze (hold position),
//        l_press/r_press (press pulses), led[8:0] (one-hot, led[8] = left end),
//        at_left = led[8], at_right = led[0].
// Optional feature: TUG_DEBOUNCE_EN (debounce inside tug_key_cond).
module tug_field
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_l,
    input  logic              key_r,
    input  logic              freeze,
    output logic              l_press,
    output logic              r_press,
    output logic [N_LEDS-1:0] led,
    output logic              at_left,
    output logic              at_right
);

    pos_t pos;
    pos_t pos_next;

    tug_key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_l (
        .clk   (clk),
        .reset (reset),
        .key   (key_l),
        .press (l_press)
    );

    tug_key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_r (
        .clk   (clk),
        .reset (reset),
        .key   (key_r),
        .press (r_press)
    );

    // Simultaneous presses cancel; the ends saturate rather than wrap so the
    // victory checker sees the light parked on the edge LED.
    always_comb begin
        pos_next = pos;
        if (!freeze) begin
            if (l_press && !r_press && pos != pos_t'(POS_MAX)) begin
                pos_next = pos + 4'd1;
            end else if (r_press && !l_press && pos != pos_t'(POS_MIN)) begin
                pos_next = pos - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos <= pos_t'(POS_CENTRE);
        end else begin
            pos <= pos_next;
        end
    end

    assign led      = pos_to_led(pos);
    assign at_left  = led[N_LEDS-1];
    assign at_right = led[0];

endmodule

// File: tb/tb_tug_field.sv
// tb/tb_tug_field.sv - self-checking scoreboard bench for tug_field
module tb_tug_field;

`ifdef TUG_DEBOUNCE_EN
    localparam int LAT  = 20;
    localparam int HOLD = 40;
`else
    localparam int LAT  = 3;
    localparam int HOLD = 5;
`endif
    localparam logic [8:0] CENTRE_LED = 9'b000010000;

    logic       clk;
    logic       reset;
    logic       key_l;
    logic       key_r;
    logic       freeze;
    logic       l_press;
    logic       r_press;
    logic [8:0] led;
    logic       at_left;
    logic       at_right;

    typedef struct {
        logic       l;
        logic       r;
        int         cyc;
        logic [8:0] led;
        logic       al;
        logic       ar;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t pend;
    bit  pend_v;
    int  cyc_n;
    int  mpos;
    int  checks;
    int  errors;

    tug_field #(.DEBOUNCE_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .key_l    (key_l),
        .key_r    (key_r),
        .freeze   (freeze),
        .l_press  (l_press),
        .r_press  (r_press),
        .led      (led),
        .at_left  (at_left),
        .at_right (at_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a pulse becomes an observation once the following cycle's LEDs are known.
    initial begin
        cyc_n  = 0;
        pend_v = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (pend_v) begin
                pend.led = led;
                pend.al  = at_left;
                pend.ar  = at_right;
                obs_q.push_back(pend);
                pend_v = 0;
            end
            if (l_press || r_press) begin
                pend.l   = l_press;
                pend.r   = r_press;
                pend.cyc = cyc_n;
                pend_v   = 1;
            end
        end
    end

    // Drives one press (or simultaneous pair) and records what the DUT must produce.
    task automatic drive_key(input logic pl, input logic pr, input int hold);
        ev_t e;
        if (!freeze) begin
            if (pl && !pr && mpos < 9) mpos++;
            else if (pr && !pl && mpos > 1) mpos--;
        end
        @(posedge clk); #1;
        e.l   = pl;
        e.r   = pr;
        e.cyc = cyc_n + LAT;
        e.led = 9'd1 << (mpos - 1);
        e.al  = e.led[8];
        e.ar  = e.led[0];
        if (pl || pr) exp_q.push_back(e);
        key_l = pl;
        key_r = pr;
        repeat (hold) @(posedge clk);
        #1;
        key_l = 1'b0;
        key_r = 1'b0;
        repeat (LAT + 4) @(posedge clk);
    endtask

    task automatic test_reset();
        ev_t e, o;
        key_l = 1'b1;
        key_r = 1'b1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (led !== CENTRE_LED) begin errors++; $display("FAIL reset_led: got %b want %b", led, CENTRE_LED); end
        checks++;
        if (l_press !== 1'b0 || r_press !== 1'b0) begin
            errors++; $display("FAIL reset_press: got l=%b r=%b want 0 0", l_press, r_press);
        end
        @(posedge clk); #1;
        e.l = 1; e.r = 1; e.cyc = cyc_n + LAT; e.led = CENTRE_LED; e.al = 0; e.ar = 0;
        exp_q.push_back(e);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (l_press !== 1'b0 || r_press !== 1'b0) begin
            errors++; $display("FAIL post_reset_pulse: got l=%b r=%b want 0 0", l_press, r_press);
        end
        repeat (HOLD) @(posedge clk);
        #1;
        key_l = 1'b0;
        key_r = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        drive_key(1'b1, 1'b0, HOLD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL reset_sb: got no pulse, want l=%b r=%b cyc=%0d", e.l, e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led || o.al !== e.al || o.ar !== e.ar) begin
                    errors++;
                    $display("FAIL reset_sb: got l=%b r=%b cyc=%0d led=%b al=%b ar=%b want l=%b r=%b cyc=%0d led=%b al=%b ar=%b",
                             o.l, o.r, o.cyc, o.led, o.al, o.ar, e.l, e.r, e.cyc, e.led, e.al, e.ar);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL reset_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_midgame_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mpos = 5;
        @(negedge clk);
        checks++;
        if (led !== CENTRE_LED) begin errors++; $display("FAIL midgame_reset_led: got %b want %b", led, CENTRE_LED); end
    endtask

    task automatic test_walk_left();
        ev_t e, o;
        repeat (6) drive_key(1'b1, 1'b0, HOLD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL walk_left_sb: got no pulse, want l=%b r=%b cyc=%0d", e.l, e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led || o.al !== e.al || o.ar !== e.ar) begin
                    errors++;
                    $display("FAIL walk_left_sb: got l=%b r=%b cyc=%0d led=%b al=%b ar=%b want l=%b r=%b cyc=%0d led=%b al=%b ar=%b",
                             o.l, o.r, o.cyc, o.led, o.al, o.ar, e.l, e.r, e.cyc, e.led, e.al, e.ar);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL walk_left_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
        @(negedge clk);
        checks++;
        if (led !== 9'b100000000 || at_left !== 1'b1) begin
            errors++; $display("FAIL left_saturate: got led=%b at_left=%b want 100000000 1", led, at_left);
        end
    endtask

    task automatic test_simultaneous();
        ev_t e, o;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mpos = 5;
        drive_key(1'b1, 1'b1, HOLD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL both_sb: got no pulse, want l=%b r=%b cyc=%0d", e.l, e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led || o.al !== e.al || o.ar !== e.ar) begin
                    errors++;
                    $display("FAIL both_sb: got l=%b r=%b cyc=%0d led=%b want l=%b r=%b cyc=%0d led=%b",
                             o.l, o.r, o.cyc, o.led, e.l, e.r, e.cyc, e.led);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL both_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
        @(negedge clk);
        checks++;
        if (led !== CENTRE_LED) begin errors++; $display("FAIL both_led: got %b want %b", led, CENTRE_LED); end
    endtask

    task automatic test_freeze();
        ev_t e, o;
        freeze = 1'b1;
        repeat (3) drive_key(1'b0, 1'b1, HOLD);
        freeze = 1'b0;
        drive_key(1'b0, 1'b1, HOLD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL freeze_sb: got no pulse, want l=%b r=%b cyc=%0d", e.l, e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led || o.al !== e.al || o.ar !== e.ar) begin
                    errors++;
                    $display("FAIL freeze_sb: got l=%b r=%b cyc=%0d led=%b want l=%b r=%b cyc=%0d led=%b",
                             o.l, o.r, o.cyc, o.led, e.l, e.r, e.cyc, e.led);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL freeze_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
        @(negedge clk);
        checks++;
        if (led !== 9'b000001000) begin errors++; $display("FAIL unfreeze_led: got %b want 000001000", led); end
    endtask

    task automatic test_walk_right();
        ev_t e, o;
        repeat (4) drive_key(1'b0, 1'b1, HOLD);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL walk_right_sb: got no pulse, want l=%b r=%b cyc=%0d", e.l, e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led || o.al !== e.al || o.ar !== e.ar) begin
                    errors++;
                    $display("FAIL walk_right_sb: got l=%b r=%b cyc=%0d led=%b ar=%b want l=%b r=%b cyc=%0d led=%b ar=%b",
                             o.l, o.r, o.cyc, o.led, o.ar, e.l, e.r, e.cyc, e.led, e.ar);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL walk_right_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
        @(negedge clk);
        checks++;
        if (led !== 9'b000000001 || at_right !== 1'b1) begin
            errors++; $display("FAIL right_saturate: got led=%b at_right=%b want 000000001 1", led, at_right);
        end
    endtask

    task automatic test_hold();
        ev_t e, o;
        drive_key(1'b1, 1'b0, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL hold_sb: got no pulse, want l=%b r=%b cyc=%0d", e.l, e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led) begin
                    errors++;
                    $display("FAIL hold_sb: got l=%b r=%b cyc=%0d led=%b want l=%b r=%b cyc=%0d led=%b",
                             o.l, o.r, o.cyc, o.led, e.l, e.r, e.cyc, e.led);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL hold_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

`ifdef TUG_DEBOUNCE_EN
    task automatic test_debounce_glitch();
        ev_t e, o;
        logic [8:0] led_before;
        @(negedge clk);
        led_before = led;
        @(posedge clk); #1;
        key_r = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        key_r = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_q.size() != 0 || led !== led_before) begin
            errors++; $display("FAIL glitch: got %0d pulses led=%b want 0 pulses led=%b", obs_q.size(), led, led_before);
            obs_q.delete();
        end
        drive_key(1'b0, 1'b1, 40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL debounce_sb: got no pulse, want r=%b cyc=%0d", e.r, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.l !== e.l || o.r !== e.r || o.cyc != e.cyc || o.led !== e.led) begin
                    errors++;
                    $display("FAIL debounce_sb: got l=%b r=%b cyc=%0d led=%b want l=%b r=%b cyc=%0d led=%b",
                             o.l, o.r, o.cyc, o.led, e.l, e.r, e.cyc, e.led);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL debounce_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        mpos   = 5;
        reset  = 1'b1;
        key_l  = 1'b0;
        key_r  = 1'b0;
        freeze = 1'b0;
        test_reset();
        test_midgame_reset();
        test_walk_left();
        test_simultaneous();
        test_freeze();
        test_walk_right();
        test_hold();
`ifdef TUG_DEBOUNCE_EN
        test_debounce_glitch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
